// File: rtl/lcd_phrase_sequencer.sv
// Byte-level feeder for the character-LCD nibble writer: power-up wait, init
// command sequence, then on request a DDRAM address byte followed by a phrase.
module lcd_phrase_sequencer #(
   parameter int N_CHARS        = 10,
   parameter int POWERUP_CYCLES = 750000,
   parameter int CLEAR_CYCLES   = 82000
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   iStart,
   input  logic                   iLine,
   input  logic [8*N_CHARS-1:0]   iPhrase,
   input  logic                   iByteAck,
   output logic [7:0]             oByte,
   output logic                   oRS,
   output logic                   oByteValid,
   output logic                   oReady,
   output logic                   oInitDone,
   output logic                   oDone
);

   localparam int IDX_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CHARS - 1);
   localparam logic [31:0]      PWR_LIMIT = 32'(POWERUP_CYCLES - 1);
   localparam logic [31:0]      CLR_LIMIT = 32'(CLEAR_CYCLES - 1);

   localparam logic [2:0] PWR_WAIT  = 3'd0;
   localparam logic [2:0] INIT_CMD  = 3'd1;
   localparam logic [2:0] CLR_WAIT  = 3'd2;
   localparam logic [2:0] IDLE      = 3'd3;
   localparam logic [2:0] SET_ADDR  = 3'd4;
   localparam logic [2:0] SEND_CHAR = 3'd5;
   localparam logic [2:0] DONE      = 3'd6;

   logic [2:0]             state;
   logic [31:0]            waitCount;
   logic [1:0]             cmdIdx;
   logic [IDX_W-1:0]       charIdx;
   logic [8*N_CHARS-1:0]   phraseReg;
   logic [7:0]             initByte;

   // Function set (4-bit, 2 lines), entry mode, display on, clear display.
   always_comb begin
      initByte = 8'h01;
      case (cmdIdx)
         2'd0:    initByte = 8'h28;
         2'd1:    initByte = 8'h06;
         2'd2:    initByte = 8'h0C;
         default: initByte = 8'h01;
      endcase
   end

   // The phrase is shifted out from the low byte, so char k sits in [7:0] on its turn.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= PWR_WAIT;
         waitCount  <= '0;
         cmdIdx     <= '0;
         charIdx    <= '0;
         // NOTE: the phrase register is cleared too so a reset never leaves a stale phrase behind.
         phraseReg  <= '0;
         oByte      <= '0;
         oRS        <= 1'b0;
         oByteValid <= 1'b0;
         oReady     <= 1'b0;
         oInitDone  <= 1'b0;
         oDone      <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state)
            PWR_WAIT: begin
               if (waitCount >= PWR_LIMIT) begin
                  waitCount  <= '0;
                  cmdIdx     <= '0;
                  oByte      <= 8'h28;
                  oRS        <= 1'b0;
                  oByteValid <= 1'b1;
                  state      <= INIT_CMD;
               end else begin
                  waitCount <= waitCount + 32'd1;
               end
            end

            INIT_CMD: begin
               if (oByteValid) begin
                  if (iByteAck) begin
                     oByteValid <= 1'b0;
                     if (cmdIdx == 2'd3) state <= CLR_WAIT;
                     else                cmdIdx <= cmdIdx + 2'd1;
                  end
               end else begin
                  oByte      <= initByte;
                  oRS        <= 1'b0;
                  oByteValid <= 1'b1;
               end
            end

            CLR_WAIT: begin
               if (waitCount >= CLR_LIMIT) begin
                  waitCount <= '0;
                  oInitDone <= 1'b1;
                  oReady    <= 1'b1;
                  state     <= IDLE;
               end else begin
                  waitCount <= waitCount + 32'd1;
               end
            end

            IDLE: begin
               if (iStart) begin
                  phraseReg  <= iPhrase;
                  charIdx    <= '0;
                  oReady     <= 1'b0;
                  oByte      <= {1'b1, iLine, 6'b0};
                  oRS        <= 1'b0;
                  oByteValid <= 1'b1;
                  state      <= SET_ADDR;
               end
            end

            SET_ADDR: begin
               if (oByteValid && iByteAck) begin
                  oByteValid <= 1'b0;
                  charIdx    <= '0;
                  state      <= SEND_CHAR;
               end
            end

            SEND_CHAR: begin
               if (oByteValid) begin
                  if (iByteAck) begin
                     oByteValid <= 1'b0;
                     phraseReg  <= phraseReg >> 8;
                     if (charIdx == LAST_IDX) begin
                        oDone <= 1'b1;
                        state <= DONE;
                     end else begin
                        charIdx <= charIdx + IDX_W'(1);
                     end
                  end
               end else begin
                  oByte      <= phraseReg[7:0];
                  oRS        <= 1'b1;
                  oByteValid <= 1'b1;
               end
            end

            DONE: begin
               oReady <= 1'b1;
               state  <= IDLE;
            end

            default: begin
               oByteValid <= 1'b0;
               waitCount  <= '0;
               state      <= PWR_WAIT;
            end
         endcase
      end
   end

endmodule
